// File: rtl/down_count_tick_gen.sv
// Control stage for a 4-bit down counter: emits a reload pulse, then periodic
// count-enable ticks, either free-running or for a fixed burst length.
module down_count_tick_gen #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DIV_W-1:0]   div_val,
  input  logic [BURST_W-1:0] burst_len,
  output logic               load,
  output logic               tick,
  output logic               running,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_pre, w_pre_nxt, w_pre_cur;
  logic [BURST_W-1:0] r_bcnt, w_bcnt_nxt, w_bcnt_cur;
  logic               r_mode, w_mode_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [BURST_W-1:0] r_blen, w_blen_nxt;
  logic               r_load, w_load_nxt;
  logic               r_tick, w_tick_nxt;
  logic               r_running, w_running_nxt;
  logic               r_done, w_done_nxt;

  // In LOAD the counters are treated as already holding the shadow values,
  // so div=0 ticks and burst_len=0 completes on the LOAD->RUN edge.
  assign w_pre_cur  = (r_state == S_LOAD) ? r_div  : r_pre;
  assign w_bcnt_cur = (r_state == S_LOAD) ? r_blen : r_bcnt;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pre     <= '0;
      r_bcnt    <= '0;
      r_mode    <= 1'b0;
      r_div     <= '0;
      r_blen    <= '0;
      r_load    <= 1'b0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_mode    <= w_mode_nxt;
      r_div     <= w_div_nxt;
      r_blen    <= w_blen_nxt;
      r_load    <= w_load_nxt;
      r_tick    <= w_tick_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_pre_nxt     = r_pre;
    w_bcnt_nxt    = r_bcnt;
    w_mode_nxt    = r_mode;
    w_div_nxt     = r_div;
    w_blen_nxt    = r_blen;
    w_load_nxt    = 1'b0;
    w_tick_nxt    = 1'b0;
    w_running_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_mode_nxt    = mode;
          w_div_nxt     = div_val;
          w_blen_nxt    = burst_len;
          w_state_nxt   = S_LOAD;
          w_load_nxt    = 1'b1;
          w_running_nxt = 1'b1;
        end
      end
      S_LOAD, S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_mode && (w_bcnt_cur == '0)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt   = S_RUN;
          w_running_nxt = 1'b1;
          w_bcnt_nxt    = w_bcnt_cur;
          if (w_pre_cur == '0) begin
            w_tick_nxt = 1'b1;
            w_pre_nxt  = r_div;
            if (r_mode) w_bcnt_nxt = w_bcnt_cur - BURST_W'(1);
          end else begin
            w_pre_nxt = w_pre_cur - DIV_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign load    = r_load;
  assign tick    = r_tick;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_down_count_tick_gen.sv
// Directed bench for down_count_tick_gen: cycle tables plus hand sequences
// for reset, async reset mid-burst and post-capture input changes.
module tb_down_count_tick_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, mode;
  logic [7:0] div_val;
  logic [3:0] burst_len;
  logic       load, tick, running, done;

  int total = 0;
  int bad   = 0;

  // Expected output encodings {load, tick, running, done}.
  localparam logic [3:0] L = 4'b1010;
  localparam logic [3:0] T = 4'b0110;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] D = 4'b0001;
  localparam logic [3:0] Z = 4'b0000;

  typedef struct {
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] div;
    logic [3:0] blen;
    logic [3:0] exp;
  } vec_t;

  vec_t vq[$];

  down_count_tick_gen #(.DIV_W(8), .BURST_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .div_val(div_val), .burst_len(burst_len),
    .load(load), .tick(tick), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic add(input logic s, input logic p, input logic m,
                     input logic [7:0] d, input logic [3:0] b, input logic [3:0] e);
    vec_t v;
    v.start = s; v.stop = p; v.mode = m; v.div = d; v.blen = b; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] e);
    logic [3:0] act;
    act = {load, tick, running, done};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got ltrd=%b expected ltrd=%b at %0t", name, act, e, $time);
    end
  endtask

  task automatic cyc(input logic s, input logic p, input logic m,
                     input logic [7:0] d, input logic [3:0] b);
    @(negedge clk);
    start = s; stop = p; mode = m; div_val = d; burst_len = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; stop = 1'b0; mode = 1'b0;
    div_val = 8'd0; burst_len = 4'd0;

    // Reset held with start high, then first sampled start loads.
    @(posedge clk); #1 check("rst_hold0", Z);
    @(posedge clk); #1 check("rst_hold1", Z);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 check("rst_release_load", L);
    cyc(0, 1, 0, 0, 0); check("rst_stop_idle", Z);

    // Continuous div=3: ticks C5,C9,C13,C17; div_val changes ignored.
    add(1, 0, 0, 8'd3, 4'd0, L);
    for (int k = 2; k <= 17; k++) add(0, 0, 0, 8'd9, 4'd0, (k % 4 == 1) ? T : R);
    add(0, 1, 0, 8'd3, 4'd0, Z);
    add(1, 1, 0, 8'd3, 4'd0, Z);
    add(0, 0, 0, 8'd3, 4'd0, Z);
    // Burst div=1 len=3: ticks C3,C5,C7, done C8; mode/len changes ignored.
    add(1, 0, 1, 8'd1, 4'd3, L);
    for (int k = 2; k <= 7; k++) add(0, 0, 0, 8'd0, 4'd9, (k % 2 == 1) ? T : R);
    add(0, 0, 0, 8'd0, 4'd9, D);
    // Restart right after done: div=0 len=4, ticks C2..C5, done C6.
    add(1, 0, 1, 8'd0, 4'd4, L);
    for (int k = 2; k <= 5; k++) add(0, 0, 1, 8'd0, 4'd4, T);
    add(0, 0, 1, 8'd0, 4'd4, D);
    // burst_len=0: no tick, done C2.
    add(1, 0, 1, 8'd5, 4'd0, L);
    add(0, 0, 1, 8'd5, 4'd0, D);
    add(0, 0, 1, 8'd5, 4'd0, Z);
    // Continuous div=2 with start held in RUN, stop at the C7 edge.
    add(1, 0, 0, 8'd2, 4'd0, L);
    add(1, 0, 0, 8'd2, 4'd0, R);
    add(1, 0, 0, 8'd2, 4'd0, R);
    add(1, 0, 0, 8'd2, 4'd0, T);
    add(1, 0, 0, 8'd2, 4'd0, R);
    add(1, 0, 0, 8'd2, 4'd0, R);
    add(0, 1, 0, 8'd2, 4'd0, Z);
    add(0, 0, 0, 8'd2, 4'd0, Z);

    foreach (vq[i]) begin
      cyc(vq[i].start, vq[i].stop, vq[i].mode, vq[i].div, vq[i].blen);
      check($sformatf("vec%0d", i), vq[i].exp);
    end

    // Async reset mid-burst at C6 (div=1 len=5).
    cyc(1, 0, 1, 1, 5); check("ar_load", L);
    for (int k = 2; k <= 6; k++) begin
      cyc(0, 0, 1, 1, 5);
      check($sformatf("ar_c%0d", k), (k % 2 == 1) ? T : R);
    end
    #2 rst = 1'b0;
    #1 check("ar_immediate", Z);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 check($sformatf("ar_hold%0d", k), Z);
    end
    @(negedge clk); rst = 1'b1;
    cyc(0, 0, 1, 1, 5); check("ar_after_release", Z);

    // div_val 1 -> 7 at C3 keeps a 2-cycle period.
    cyc(1, 0, 0, 1, 0); check("dc_load", L);
    cyc(0, 0, 0, 1, 0); check("dc_c2", R);
    for (int k = 3; k <= 9; k++) begin
      cyc(0, 0, 0, 7, 0);
      check($sformatf("dc_c%0d", k), (k % 2 == 1) ? T : R);
    end
    cyc(0, 1, 0, 7, 0); check("dc_stop", Z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_count_tick_gen.md
Name: down_count_tick_gen

Overview:
- Upstream control stage for the 4-bit down counter.
- Generates a one-cycle `load` pulse, then a stream of one-cycle `tick` enable pulses at a programmable period. The down counter reloads on `load` and decrements once per `tick`.
- Two modes: continuous (free-running ticks until stopped) and burst (exactly N ticks, then a `done` pulse).

Parameters:
- DIV_W, 8: width of the prescaler divide value; tick period = div_val+1 cycles.
- BURST_W, 4: width of the burst length and burst tick counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled each edge; begins a run when idle.
- stop  in  1  level, sampled each edge; aborts a run.
- mode  in  1  0 = continuous, 1 = burst; captured at start.
- div_val  in  DIV_W  prescale value; captured at start.
- burst_len  in  BURST_W  ticks per burst; captured at start.
- load  out  1  one-cycle pulse telling the downstream counter to reload.
- tick  out  1  one-cycle count-enable pulse to the downstream counter.
- running  out  1  high while in LOAD or RUN.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE; load, tick, running, done = 0 immediately; prescaler, burst counter and shadow registers cleared.
- States: IDLE, LOAD, RUN.
- Cycle numbering: C0 is the cycle in which start=1 is sampled. The numbers below are the cycles in which outputs are high.
- IDLE, start=1 and stop=0 at edge:
  - mode, div_val, burst_len copied into shadow registers.
  - Next state LOAD.
  - C1: load=1, running=1, tick=0.
- LOAD:
  - Prescaler preset to the shadow div; burst counter preset to shadow burst_len.
  - Next state RUN unconditionally, unless stop.
- RUN:
  - Prescaler decrements each cycle.
  - When it reaches 0, tick=1 for one cycle and the prescaler reloads the shadow div.
  - Ticks occur at C1 + k*(div+1), k = 1, 2, ...
  - div=0 gives a tick every cycle from C2.
- Burst mode:
  - Burst counter decrements on each tick.
  - The cycle after the tick that brings it to 0: done=1, running=0, tick=0, state IDLE.
  - burst_len=0: no ticks; done=1 in C2, then IDLE.
- Continuous mode: ticks indefinitely; done is never asserted.
- stop=1 at an edge in LOAD or RUN:
  - Next cycle: state IDLE, running=0, tick=0, load=0, done=0.
  - A tick that would have fallen in that cycle is suppressed.
- start and stop both high in IDLE: stop wins; remain IDLE.
- start while LOAD or RUN: ignored. Holding start high re-triggers only after returning to IDLE.
- Input changes after capture (div_val, burst_len, mode): ignored until the next start.
- Outputs load, tick and done are mutually exclusive in any cycle.
- Reset asserted mid-run: outputs drop asynchronously; no done pulse is emitted.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> all outputs 0; release -> load=1 in the cycle after the first sampled start.
- Continuous, div_val=3, start pulse at C0 -> load at C1, ticks at C5, C9, C13, C17; running=1 throughout; done never high. The downstream counter reloads on load, then decrements once per tick.
- Burst, div_val=1, burst_len=3 -> load C1, ticks C3, C5, C7, done C8, running low from C8; second start accepted at C8 or later.
- Edge cases: div_val=0, burst_len=4 -> ticks C2–C5, done C6. burst_len=0 -> no tick, done C2.
- Stop and invalid start: continuous div_val=2, stop sampled at the C7 edge (tick due at C7) -> tick at C4 only; C7 onward all outputs 0. Start asserted during RUN -> no second load.
- Async reset mid-burst at C6 (div_val=1, burst_len=5) -> outputs 0 immediately, no done. Changing div_val from 1 to 7 at C3 of a run -> period stays 2 cycles.
